// File: rtl/vga_frame_source.sv
// vga_frame_source
//   Holds one downscaled image in on-chip RAM and paints it onto a VGA raster.
//   A class bar along the bottom of the screen shows the latest classifier
//   result. Images arrive as a stream of 12-bit beats, and the first beat of
//   each image carries wr_sof.
//
// Ports
//   clk          system clock (only clock)
//   rst_n        asynchronous active-low reset, release synchronised inside
//   wr_valid     write beat valid
//   wr_ready     write beat accepted (high whenever out of reset)
//   wr_sof       first pixel of an image, qualified by wr_valid
//   wr_data      pixel {R[11:8],G[7:4],B[3:0]}
//   x, y         current screen column/row from the VGA timing block
//   class_valid  one-cycle strobe qualifying class_id
//   class_id     classifier result
//   r, g, b      pixel colour, 2 cycles after x/y
//   frame_done   one-cycle pulse after the last pixel of an image is written
//   sof_err      sticky: a beat arrived in IDLE without wr_sof
//
// Write FSM
//   state | meaning
//   IDLE  | waiting for a wr_sof beat; other beats are dropped and flagged
//   LOAD  | storing beats at wr_addr until the last pixel of the image
module vga_frame_source #(
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int SCALE_SH = 2,
  parameter int BAR_Y0   = 456
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        wr_sof,
  input  logic [11:0] wr_data,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        class_valid,
  input  logic [1:0]  class_id,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        frame_done,
  output logic        sof_err
);

  localparam int DEPTH = IMG_W * IMG_H;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [10:0]   H_ACT   = 11'd640;
  localparam logic [10:0]   V_ACT   = 11'd480;
  localparam logic [10:0]   BAR_ROW = 11'(BAR_Y0);

  typedef enum logic {IDLE, LOAD} state_t;
  typedef enum logic [1:0] {RG_BLANK, RG_PIXEL, RG_BAR} region_t;

  // Reset release synchroniser; wr_ready is its second stage so the write
  // path wakes up on the second edge after rst_n rises.
  logic [1:0] rst_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign wr_ready = rst_sync[1];

  logic accept;
  assign accept = wr_valid & wr_ready;

  // Write FSM
  state_t        state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          we;
  logic [AW-1:0] wa;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    done_d    = 1'b0;
    err_d     = err_q;
    we        = 1'b0;
    wa        = '0;
    if (accept) begin
      if (wr_sof) begin
        // sof always (re)starts an image, whatever the state
        we        = 1'b1;
        wa        = '0;
        wr_addr_d = AW'(1);
        state_d   = LOAD;
      end else if (state_q == LOAD) begin
        we = 1'b1;
        wa = wr_addr_q;
        if (wr_addr_q == LAST) begin
          done_d    = 1'b1;
          wr_addr_d = '0;
          state_d   = IDLE;
        end else begin
          wr_addr_d = wr_addr_q + AW'(1);
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign frame_done = done_q;
  assign sof_err    = err_q;

  // Classifier result; a strobe in the same cycle as a sof beat wins.
  logic       result_valid;
  logic [1:0] class_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid <= 1'b0;
      class_q      <= 2'd0;
    end else if (class_valid) begin
      result_valid <= 1'b1;
      class_q      <= class_id;
    end else if (accept && wr_sof) begin
      result_valid <= 1'b0;
    end
  end

  // Image RAM: one write port, one registered read port, read-first.
  // No reset so it maps onto block RAM and keeps the image across reset.
  logic [11:0]   mem [DEPTH];
  logic [11:0]   ram_q;
  logic [AW-1:0] rd_addr;

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wr_data;
    ram_q <= mem[rd_addr];
  end

  // Read pipeline: stage 1 registers the address and the region decision,
  // stage 2 runs alongside the RAM output register.
  logic [AW-1:0] addr_calc;
  region_t       region_c, region1, region2;
  logic [11:0]   bar_c, bar1, bar2;

  assign addr_calc = AW'(y >> SCALE_SH) * AW'(IMG_W) + AW'(x >> SCALE_SH);

  always_comb begin
    region_c = RG_BLANK;
    if (x < H_ACT && y < V_ACT) begin
      if (y >= BAR_ROW) region_c = RG_BAR;
      else              region_c = RG_PIXEL;
    end
  end

  always_comb begin
    bar_c = 12'h000;
    if (result_valid) begin
      case (class_q)
        2'd0:    bar_c = 12'h0F0;
        2'd1:    bar_c = 12'hF00;
        2'd2:    bar_c = 12'hFF0;
        default: bar_c = 12'h888;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      region1 <= RG_BLANK;
      region2 <= RG_BLANK;
      bar1    <= 12'h000;
      bar2    <= 12'h000;
    end else begin
      rd_addr <= addr_calc;
      region1 <= region_c;
      region2 <= region1;
      bar1    <= bar_c;
      bar2    <= bar1;
    end
  end

  logic [11:0] rgb;

  always_comb begin
    rgb = 12'h000;
    case (region2)
      RG_PIXEL: rgb = ram_q;
      RG_BAR:   rgb = bar2;
      default:  rgb = 12'h000;
    endcase
  end

  assign r = rgb[11:8];
  assign g = rgb[7:4];
  assign b = rgb[3:0];

endmodule

// File: tb/tb_vga_frame_source.sv
module tb_vga_frame_source;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_sof = 1'b0;
  logic [11:0] wr_data = 12'h000;
  logic [10:0] x = 11'd0;
  logic [10:0] y = 11'd0;
  logic        class_valid = 1'b0;
  logic [1:0]  class_id = 2'd0;
  logic        wr_ready;
  logic [3:0]  r, g, b;
  logic        frame_done;
  logic        sof_err;
  logic [11:0] rgb;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int d0;

  vga_frame_source dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_sof      (wr_sof),
    .wr_data     (wr_data),
    .x           (x),
    .y           (y),
    .class_valid (class_valid),
    .class_id    (class_id),
    .r           (r),
    .g           (g),
    .b           (b),
    .frame_done  (frame_done),
    .sof_err     (sof_err)
  );

  assign rgb = {r, g, b};

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream n beats for addresses first..first+n-1; data is addr[11:0] or its
  // inverse. The task returns 1ns after the edge accepting the final beat.
  task automatic load(input int first, input int n, input bit inv, input bit sof_first);
    logic [11:0] v;
    for (int i = 0; i < n; i++) begin
      v        = 12'(first + i);
      wr_valid = 1'b1;
      wr_sof   = sof_first && (i == 0);
      wr_data  = inv ? ~v : v;
      tick();
    end
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
  endtask

  task automatic look(input int px, input int py, input logic [11:0] exp, input string tag);
    x = 11'(px);
    y = 11'(py);
    tick();
    tick();
    check(tag, rgb, exp);
  endtask

  task automatic strobe_class(input logic [1:0] id);
    class_valid = 1'b1;
    class_id    = id;
    tick();
    class_valid = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    check("rst_rgb", rgb, 12'h000);
    check("rst_ready", wr_ready, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_err", sof_err, 1'b0);
    rst_n = 1'b1;
    tick();
    check("ready_edge1", wr_ready, 1'b0);
    tick();
    check("ready_edge2", wr_ready, 1'b1);

    // full image, pattern addr[11:0]
    d0 = done_cnt;
    load(0, 19199, 1'b0, 1'b1);
    check("no_early_done", done_cnt - d0, 0);
    load(19199, 1, 1'b0, 1'b0);
    check("done_pulse", frame_done, 1'b1);
    tick();
    check("done_once_low", frame_done, 1'b0);
    check("done_count", done_cnt - d0, 1);

    // read latency and addressing
    x = 11'd0; y = 11'd0;
    tick(); tick();
    x = 11'd8; y = 11'd4;
    tick();
    check("latency_1cyc", rgb, 12'h000);
    tick();
    check("pix_8_4", rgb, 12'h0A2);
    look(639, 455, 12'h73F, "pix_last_col");
    look(100, 100, 12'hFB9, "pix_100_100");
    look(700, 100, 12'h000, "x_oob");
    look(100, 500, 12'h000, "y_oob");
    look(0, 456, 12'h000, "bar_noresult");

    // stray beat in IDLE
    check("err_before", sof_err, 1'b0);
    load(0, 1, 1'b1, 1'b0);
    check("err_set", sof_err, 1'b1);
    look(0, 0, 12'h000, "ram_unchanged");
    check("err_sticky", sof_err, 1'b1);

    // restart at beat 300, then full inverted image from the new sof
    d0 = done_cnt;
    load(0, 300, 1'b1, 1'b1);
    load(0, 19199, 1'b1, 1'b1);
    check("restart_no_early", done_cnt - d0, 0);
    load(19199, 1, 1'b1, 1'b0);
    check("restart_done", frame_done, 1'b1);
    tick();
    check("restart_count", done_cnt - d0, 1);
    look(8, 4, 12'hF5D, "restart_pix");
    check("restart_err_kept", sof_err, 1'b1);

    // class bar
    strobe_class(2'd1);
    look(100, 470, 12'hF00, "bar_id1");
    strobe_class(2'd3);
    look(100, 470, 12'h888, "bar_id3");
    strobe_class(2'd0);
    look(100, 470, 12'h0F0, "bar_id0");
    wr_valid = 1'b1; wr_sof = 1'b1; wr_data = 12'hFFF;
    class_valid = 1'b1; class_id = 2'd2;
    tick();
    wr_valid = 1'b0; wr_sof = 1'b0; class_valid = 1'b0;
    look(100, 470, 12'hFF0, "bar_class_wins");
    load(0, 1, 1'b1, 1'b1);
    look(100, 470, 12'h000, "bar_sof_clears");

    // reset in the middle of a load (after beat 5000)
    load(1, 4999, 1'b1, 1'b0);
    look(100, 100, 12'h046, "pre_reset_pix");
    #2 rst_n = 1'b0;
    #1;
    check("async_rgb", rgb, 12'h000);
    check("async_ready", wr_ready, 1'b0);
    check("async_err", sof_err, 1'b0);
    check("async_done", frame_done, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rel_ready_edge1", wr_ready, 1'b0);
    tick();
    check("rel_ready_edge2", wr_ready, 1'b1);
    look(100, 100, 12'h046, "ram_kept");
    load(0, 1, 1'b0, 1'b0);
    check("idle_after_reset", sof_err, 1'b1);
    d0 = done_cnt;
    load(0, 19200, 1'b0, 1'b1);
    check("reload_done", frame_done, 1'b1);
    tick();
    check("reload_count", done_cnt - d0, 1);
    look(8, 4, 12'h0A2, "reload_pix");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
